// File: rtl/dlx_regfile.sv
// DLX architectural register file: 32 GPRs (R0 hardwired to zero) and 32 FPRs, combinational reads.
// Optional macro DLX_REGFILE_WB_BYPASS_EN forwards same-cycle write data onto the read buses.
module dlx_regfile #(
   parameter int NREGS    = 32,
   parameter int DW       = 32,
   parameter int LINK_REG = 31,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [0:AW-1] rs1_addr,
   input  logic [0:AW-1] rs2_addr,
   output logic [0:DW-1] busA,
   output logic [0:DW-1] busB,
   input  logic [0:AW-1] fs1_addr,
   input  logic [0:AW-1] fs2_addr,
   output logic [0:DW-1] fbusA,
   output logic [0:DW-1] fbusB,
   input  logic          gp_we,
   input  logic [0:AW-1] gp_waddr,
   input  logic [0:DW-1] gp_wdata,
   input  logic          fp_we,
   input  logic [0:AW-1] fp_waddr,
   input  logic [0:DW-1] fp_wdata,
   input  logic          link_we,
   input  logic [0:DW-1] link_data
);

   // Reset asserts immediately but write acceptance resumes only after two clean edges.
   logic [1:0] rst_sync_q;
   logic       wr_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign wr_ok = rst_sync_q[1];

   logic [0:DW-1] gpr_word [NREGS];
   logic [0:DW-1] fpr_word [NREGS];

   assign gpr_word[0] = '0;

   genvar gi;
   generate
      for (gi = 1; gi < NREGS; gi++) begin : g_gpr
         logic [0:DW-1] r_q, r_d;

         // The link write shadows a colliding gp write to the link register.
         always_comb begin
            r_d = r_q;
            if (wr_ok) begin
               if (link_we && (gi == LINK_REG)) begin
                  r_d = link_data;
               end else if (gp_we && (gp_waddr == AW'(gi))) begin
                  r_d = gp_wdata;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_q <= '0;
            end else begin
               r_q <= r_d;
            end
         end

         assign gpr_word[gi] = r_q;
      end

      for (gi = 0; gi < NREGS; gi++) begin : g_fpr
         logic [0:DW-1] r_q, r_d;

         always_comb begin
            r_d = r_q;
            if (wr_ok && fp_we && (fp_waddr == AW'(gi))) begin
               r_d = fp_wdata;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_q <= '0;
            end else begin
               r_q <= r_d;
            end
         end

         assign fpr_word[gi] = r_q;
      end
   endgenerate

`ifdef DLX_REGFILE_WB_BYPASS_EN
   function automatic logic [0:DW-1] gpr_read(input logic [0:AW-1] a);
      gpr_read = gpr_word[a];
      if (rst_n && wr_ok && (a != '0)) begin
         if (link_we && (a == AW'(LINK_REG))) begin
            gpr_read = link_data;
         end else if (gp_we && (a == gp_waddr)) begin
            gpr_read = gp_wdata;
         end
      end
   endfunction

   function automatic logic [0:DW-1] fpr_read(input logic [0:AW-1] a);
      fpr_read = fpr_word[a];
      if (rst_n && wr_ok && fp_we && (a == fp_waddr)) begin
         fpr_read = fp_wdata;
      end
   endfunction
`else
   function automatic logic [0:DW-1] gpr_read(input logic [0:AW-1] a);
      gpr_read = gpr_word[a];
   endfunction

   function automatic logic [0:DW-1] fpr_read(input logic [0:AW-1] a);
      fpr_read = fpr_word[a];
   endfunction
`endif

   always_comb begin
      busA  = gpr_read(rs1_addr);
      busB  = gpr_read(rs2_addr);
      fbusA = fpr_read(fs1_addr);
      fbusB = fpr_read(fs2_addr);
   end

endmodule
